// File: rtl/dcache_pkg.sv
// dcache_pkg: shared definitions for the direct-mapped data cache.
//   state_t        - cache controller states (IDLE, REFILL)
//   BYTE_OFF_W     - byte-in-word address bits, ignored for lookup
//   DECODE_MSB     - highest CPU address bit taken into the tag
//   *_LSB / *_MSB  - default geometry bit ranges (64 lines x 4 words)
package dcache_pkg;

    typedef enum logic {
        IDLE,
        REFILL
    } state_t;

    localparam int unsigned BYTE_OFF_W = 2;
    localparam int unsigned DECODE_MSB = 16;

    localparam int unsigned OFFSET_LSB = 2;
    localparam int unsigned OFFSET_MSB = 3;
    localparam int unsigned INDEX_LSB  = 4;
    localparam int unsigned INDEX_MSB  = 9;
    localparam int unsigned TAG_LSB    = 10;
    localparam int unsigned TAG_MSB    = 16;

endpackage

// File: rtl/dcache_tagram.sv
// dcache_tagram: tag + valid storage for the direct-mapped data cache.
//   clk, rst_n         - clock, synchronous active-low reset (valid bits only)
//   rd_idx             - lookup index; rd_tag / rd_valid returned combinationally
//   wr_en/wr_idx/wr_tag - write a tag and set the line valid
//   clr_en/clr_idx     - clear the valid bit of one line
// Tags are not reset; a line is meaningful only while its valid bit is set.
module dcache_tagram #(
    parameter int unsigned LINES = 64,
    parameter int unsigned TAG_W = 7,
    parameter int unsigned IDX_W = $clog2(LINES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [TAG_W-1:0] rd_tag,
    output logic             rd_valid,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);

    logic [TAG_W-1:0] tag_q [LINES];
    logic [LINES-1:0] valid_q;

    assign rd_tag   = tag_q[rd_idx];
    assign rd_valid = valid_q[rd_idx];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else begin
            if (clr_en) valid_q[clr_idx] <= 1'b0;
            if (wr_en)  valid_q[wr_idx]  <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) tag_q[wr_idx] <= wr_tag;
    end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
//   clk, rst_n            - clock, synchronous active-low reset
//   A, WD, WE, RE         - CPU address, store data, store / load requests
//   AddrMode              - CPU access size, forwarded on stores
//   RD, stall             - load data; stall while a load cannot complete
//   mem_A/mem_WD/mem_WE/mem_AddrMode - port to the data memory
//   mem_RD                - memory word, combinational from mem_A
// A load miss stalls one IDLE cycle plus WORDS_PER_LINE REFILL cycles, then
// the held request hits. hit_cnt / miss_cnt are internal statistics.
module data_cache
    import dcache_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned LINES          = 64,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] WD,
    input  logic                  WE,
    input  logic                  RE,
    input  logic [2:0]            AddrMode,
    output logic [DATA_WIDTH-1:0] RD,
    output logic                  stall,
    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    output logic                  mem_WE,
    output logic [2:0]            mem_AddrMode,
    input  logic [DATA_WIDTH-1:0] mem_RD
);

    localparam int unsigned OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned OFF_LSB = BYTE_OFF_W;
    localparam int unsigned IDX_LSB = OFF_LSB + OFF_W;
    localparam int unsigned TG_LSB  = IDX_LSB + IDX_W;
    localparam int unsigned TAG_W   = DECODE_MSB - TG_LSB + 1;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

    state_t state_q, state_d;
    logic [OFF_W-1:0] cnt_q;
    logic             just_filled_q;
    logic [31:0]      hit_cnt;
    logic [31:0]      miss_cnt;

    logic [OFF_W-1:0] a_off;
    logic [IDX_W-1:0] a_idx;
    logic [TAG_W-1:0] a_tag;
    logic [TAG_W-1:0] rd_tag;
    logic             rd_valid;
    logic             hit;
    logic             fill_done, line_clr, load_hit, load_miss;
    logic             unused_byte_off;

    logic [DATA_WIDTH-1:0] data_q [LINES*WORDS_PER_LINE];

    assign a_off = A[IDX_LSB-1:OFF_LSB];
    assign a_idx = A[TG_LSB-1:IDX_LSB];
    assign a_tag = A[DECODE_MSB:TG_LSB];
    assign unused_byte_off = ^A[BYTE_OFF_W-1:0];

    dcache_tagram #(
        .LINES (LINES),
        .TAG_W (TAG_W),
        .IDX_W (IDX_W)
    ) u_tagram (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (a_idx),
        .rd_tag   (rd_tag),
        .rd_valid (rd_valid),
        .wr_en    (fill_done),
        .wr_idx   (a_idx),
        .wr_tag   (a_tag),
        .clr_en   (line_clr),
        .clr_idx  (a_idx)
    );

    assign hit = rd_valid && (rd_tag == a_tag);
    assign RD  = data_q[{a_idx, a_off}];

    always_comb begin
        state_d      = state_q;
        stall        = 1'b0;
        mem_A        = A;
        mem_WD       = WD;
        mem_WE       = 1'b0;
        mem_AddrMode = AddrMode;
        fill_done    = 1'b0;
        line_clr     = 1'b0;
        load_hit     = 1'b0;
        load_miss    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (WE) begin
                    mem_WE   = 1'b1;
                    line_clr = hit;
                end else if (RE) begin
                    if (hit) begin
                        load_hit = 1'b1;
                    end else begin
                        load_miss = 1'b1;
                        stall     = 1'b1;
                        state_d   = REFILL;
                    end
                end
            end
            REFILL: begin
                stall = 1'b1;
                mem_A = {A[ADDR_WIDTH-1:IDX_LSB], cnt_q, {BYTE_OFF_W{1'b0}}};
                if (cnt_q == LAST_WORD) begin
                    fill_done = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Reset overrides everything so memory sees no store and the CPU no stall.
        if (!rst_n) begin
            state_d   = IDLE;
            stall     = 1'b0;
            mem_WE    = 1'b0;
            fill_done = 1'b0;
            line_clr  = 1'b0;
            load_hit  = 1'b0;
            load_miss = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            just_filled_q <= 1'b0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
        end else begin
            state_q       <= state_d;
            just_filled_q <= fill_done;
            if (load_miss)
                cnt_q <= '0;
            else if (state_q == REFILL)
                cnt_q <= cnt_q + 1'b1;
            // The held request that completes right after a refill was already
            // counted as a miss, so it is not counted again as a hit.
            if (load_hit && !just_filled_q && hit_cnt != '1)
                hit_cnt <= hit_cnt + 1'b1;
            if (load_miss && miss_cnt != '1)
                miss_cnt <= miss_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && state_q == REFILL)
            data_q[{a_idx, cnt_q}] <= mem_RD;
    end

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;
    import dcache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A, WD, RD, mem_A, mem_WD, mem_RD;
    logic        WE, RE, stall, mem_WE;
    logic [2:0]  AddrMode, mem_AddrMode;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] seen [4];
    logic [31:0] mem_arr [4096];

    always #5 clk = ~clk;

    data_cache #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .LINES          (64),
        .WORDS_PER_LINE (4)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .A            (A),
        .WD           (WD),
        .WE           (WE),
        .RE           (RE),
        .AddrMode     (AddrMode),
        .RD           (RD),
        .stall        (stall),
        .mem_A        (mem_A),
        .mem_WD       (mem_WD),
        .mem_WE       (mem_WE),
        .mem_AddrMode (mem_AddrMode),
        .mem_RD       (mem_RD)
    );

    // Word-addressed memory model: initial word i holds 0xC0DE0000 | i.
    assign mem_RD = mem_arr[mem_A[13:2]];
    always @(posedge clk) begin
        if (mem_WE) mem_arr[mem_A[13:2]] = mem_WD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a load and hold it until stall drops (bounded), then check
    // stall length and returned data. Captures mem_A in the REFILL cycles.
    task automatic do_load(input logic [31:0] addr, input int exp_stall,
                           input logic [31:0] exp_rd, input string tag);
        int n;
        A  = addr;
        RE = 1'b1;
        WE = 1'b0;
        n  = 0;
        #1;
        while (stall === 1'b1 && n < 20) begin
            if (n >= 1 && n <= 4) seen[n-1] = mem_A;
            @(posedge clk); #1;
            n++;
        end
        chk({tag, " stall cycles"}, 32'(n), 32'(exp_stall));
        chk({tag, " RD"}, RD, exp_rd);
        @(posedge clk); #1;
        RE = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem_arr[i] = 32'hC0DE0000 | 32'(i);
        rst_n = 1'b0; A = 32'h0; WD = 32'h0; WE = 1'b1; RE = 1'b1; AddrMode = 3'b000;

        // Reset: outputs quiet even with both requests asserted
        @(posedge clk); #1;
        chk("rst stall", 32'(stall), 32'd0);
        chk("rst mem_WE", 32'(mem_WE), 32'd0);
        @(posedge clk); #1;
        WE = 1'b0; RE = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rst state", 32'(u_dut.state_q), 32'(IDLE));
        chk("rst hit_cnt", u_dut.hit_cnt, 32'd0);
        chk("rst miss_cnt", u_dut.miss_cnt, 32'd0);

        // Idle passthrough
        A = 32'h0001_2340; #1;
        chk("idle mem_A", mem_A, 32'h0001_2340);
        chk("idle stall", 32'(stall), 32'd0);
        @(posedge clk); #1;

        // Cold miss, refill address walk
        do_load(32'h0001_0000, 5, 32'hC0DE0000, "cold");
        chk("cold mem_A0", seen[0], 32'h0001_0000);
        chk("cold mem_A1", seen[1], 32'h0001_0004);
        chk("cold mem_A2", seen[2], 32'h0001_0008);
        chk("cold mem_A3", seen[3], 32'h0001_000C);
        chk("cold miss_cnt", u_dut.miss_cnt, 32'd1);
        chk("cold hit_cnt", u_dut.hit_cnt, 32'd0);

        // Hit in the same line
        do_load(32'h0001_0008, 0, 32'hC0DE0002, "hit");
        chk("hit hit_cnt", u_dut.hit_cnt, 32'd1);
        chk("hit miss_cnt", u_dut.miss_cnt, 32'd1);

        // Store hit: write-through, line invalidated
        A = 32'h0001_0004; WD = 32'hDEADBEEF; AddrMode = 3'b010; WE = 1'b1; #1;
        chk("st mem_WE", 32'(mem_WE), 32'd1);
        chk("st mem_A", mem_A, 32'h0001_0004);
        chk("st mem_WD", mem_WD, 32'hDEADBEEF);
        chk("st mem_AddrMode", 32'(mem_AddrMode), 32'd2);
        chk("st stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        WE = 1'b0; #1;
        chk("st mem_WE drop", 32'(mem_WE), 32'd0);
        do_load(32'h0001_0004, 5, 32'hDEADBEEF, "st reload");
        chk("st miss_cnt", u_dut.miss_cnt, 32'd2);

        // Conflict: invalidate line 0, then thrash two tags on index 0
        A = 32'h0001_0000; WD = 32'h12345678; WE = 1'b1; #1;
        @(posedge clk); #1;
        WE = 1'b0;
        do_load(32'h0001_0000, 5, 32'h12345678, "conf1");
        do_load(32'h0001_0400, 5, 32'hC0DE0100, "conf2");
        do_load(32'h0001_0000, 5, 32'h12345678, "conf3");
        chk("conf miss_cnt", u_dut.miss_cnt, 32'd5);
        chk("conf hit_cnt", u_dut.hit_cnt, 32'd1);

        // Reset in the middle of a refill
        A = 32'h0001_0400; RE = 1'b1; #1;
        chk("ab stall idle", 32'(stall), 32'd1);
        @(posedge clk); #1;
        WE = 1'b1; #1;
        chk("ab refill stall", 32'(stall), 32'd1);
        chk("ab refill mem_A", mem_A, 32'h0001_0400);
        chk("ab refill mem_WE", 32'(mem_WE), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b0; #1;
        chk("ab rst stall", 32'(stall), 32'd0);
        chk("ab rst mem_WE", 32'(mem_WE), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; WE = 1'b0; RE = 1'b0; #1;
        chk("ab state", 32'(u_dut.state_q), 32'(IDLE));
        chk("ab stall", 32'(stall), 32'd0);
        chk("ab miss_cnt", u_dut.miss_cnt, 32'd0);
        do_load(32'h0001_0400, 5, 32'hC0DE0100, "ab reload");
        chk("ab reload miss_cnt", u_dut.miss_cnt, 32'd1);

        // WE and RE together at an uncached address: store only
        A = 32'h0001_0C00; WD = 32'hCAFEF00D; WE = 1'b1; RE = 1'b1; #1;
        chk("wr mem_WE", 32'(mem_WE), 32'd1);
        chk("wr stall", 32'(stall), 32'd0);
        @(posedge clk); #1;
        WE = 1'b0; RE = 1'b0; #1;
        chk("wr miss_cnt", u_dut.miss_cnt, 32'd1);
        chk("wr state", 32'(u_dut.state_q), 32'(IDLE));

        // Hit on the refilled line after reset
        do_load(32'h0001_040C, 0, 32'hC0DE0103, "post hit");
        chk("post hit_cnt", u_dut.hit_cnt, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
